// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Scoreboard that tracks every in-flight register write with its own
// countdown. It decides decode-stage stalls, issue and per-operand bypass
// selects from registered state. It replaces the fixed E/M/W comparator
// hazard unit.
//
// Ports
//   clk, resetn              core clock, synchronous active-low reset
//   valid_d                  decode stage holds an instruction
//   rs1_d/rs2_d, rsX_used    source registers and whether they are read
//   rd_d, regwrite_d, lat_d  destination, write enable, result latency
//   kill_d                   flush: decode instruction is discarded
//   hold                     global freeze of all scoreboard state
//   stall_d                  hold fetch/decode (combinational)
//   issue                    decode instruction issues this cycle
//   fwd_a/fwd_b              0 = register file, k = bypass with k cycles left
//   busy_vec                 pending-write flags, bit 0 always 0
//   retire, retire_rd        registered one-cycle pulse on countdown 1 -> 0
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MAX_LAT   = 4,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid_d,
  input  logic [REG_AW-1:0]   rs1_d,
  input  logic [REG_AW-1:0]   rs2_d,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic [REG_AW-1:0]   rd_d,
  input  logic                regwrite_d,
  input  logic [LAT_W-1:0]    lat_d,
  input  logic                kill_d,
  input  logic                hold,
  output logic                stall_d,
  output logic                issue,
  output logic [LAT_W-1:0]    fwd_a,
  output logic [LAT_W-1:0]    fwd_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                retire,
  output logic [REG_AW-1:0]   retire_rd
);

  localparam int unsigned     NumSlots = 1 << REG_AW;
  localparam logic [LAT_W-1:0] FwdDepth = LAT_W'(FWD_DEPTH);
  localparam logic [LAT_W-1:0] CntOne   = LAT_W'(1);

  // Registered state
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic                retire_q, retire_d;
  logic [REG_AW-1:0]   retire_rd_q, retire_rd_d;

  // View of the state over the full address space; addresses beyond
  // NUM_REGS read as idle so out-of-range operands never hazard.
  logic [NumSlots-1:0] busy_all;
  logic [LAT_W-1:0]    cnt_all [NumSlots];

  // One-hot decode of the destination, bit 0 never set
  logic [NUM_REGS-1:0] rd_sel;

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    if (g < NUM_REGS) begin : g_live
      assign busy_all[g] = busy_q[g];
      assign cnt_all[g]  = cnt_q[g];
    end else begin : g_dead
      assign busy_all[g] = 1'b0;
      assign cnt_all[g]  = '0;
    end
  end

  assign rd_sel[0] = 1'b0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_rd_sel
    assign rd_sel[g] = (rd_d == REG_AW'(g));
  end

  // Hazard detection and bypass selection
  logic             raw_a, raw_b, waw;
  logic             pend_a, pend_b;
  logic [LAT_W-1:0] cnt_a, cnt_b, cnt_rd;
  logic             wr_en;

  always_comb begin
    cnt_a  = cnt_all[rs1_d];
    cnt_b  = cnt_all[rs2_d];
    cnt_rd = cnt_all[rd_d];

    pend_a = rs1_used && (rs1_d != '0) && busy_all[rs1_d];
    pend_b = rs2_used && (rs2_d != '0) && busy_all[rs2_d];

    raw_a = valid_d && pend_a && (cnt_a > FwdDepth);
    raw_b = valid_d && pend_b && (cnt_b > FwdDepth);
    // A younger write must finish strictly after the older one
    waw   = valid_d && regwrite_d && (rd_d != '0) && busy_all[rd_d] && (cnt_rd >= lat_d);

    // While reset is asserted the state is about to be cleared, so the
    // outputs already behave as if the scoreboard were empty.
    stall_d = (resetn && (raw_a || raw_b || waw)) || hold;
    issue   = valid_d && !stall_d && !kill_d;

    fwd_a = '0;
    fwd_b = '0;
    if (resetn && pend_a && (cnt_a != '0) && (cnt_a <= FwdDepth)) begin
      fwd_a = cnt_a;
    end
    if (resetn && pend_b && (cnt_b != '0) && (cnt_b <= FwdDepth)) begin
      fwd_b = cnt_b;
    end

    wr_en = issue && regwrite_d && (lat_d != '0);
  end

  // Next-state: countdown, retire selection, issue write
  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    retire_d    = 1'b0;
    retire_rd_d = '0;

    if (!hold) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (busy_q[r]) begin
          if (cnt_q[r] == CntOne) begin
            busy_d[r] = 1'b0;
            cnt_d[r]  = '0;
            // Ascending scan: first hit is the lowest-numbered retire
            if (!retire_d) begin
              retire_d    = 1'b1;
              retire_rd_d = REG_AW'(r);
            end
          end else begin
            cnt_d[r] = cnt_q[r] - CntOne;
          end
        end
      end

      // Issue write overrides the countdown of the same entry
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (wr_en && rd_sel[r]) begin
          busy_d[r] = 1'b1;
          cnt_d[r]  = lat_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q      <= '0;
      retire_q    <= 1'b0;
      retire_rd_q <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      retire_q    <= retire_d;
      retire_rd_q <= retire_rd_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign busy_vec  = busy_q;
  assign retire    = retire_q;
  assign retire_rd = retire_rd_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned RegAw   = 5;
  localparam int unsigned LatW    = 3;

  logic               clk;
  logic               resetn;
  logic               valid_d;
  logic [RegAw-1:0]   rs1_d, rs2_d, rd_d;
  logic               rs1_used, rs2_used;
  logic               regwrite_d;
  logic [LatW-1:0]    lat_d;
  logic               kill_d;
  logic               hold;
  logic               stall_d;
  logic               issue;
  logic [LatW-1:0]    fwd_a, fwd_b;
  logic [NumRegs-1:0] busy_vec;
  logic               retire;
  logic [RegAw-1:0]   retire_rd;

  int unsigned n_checks;
  int unsigned n_pass;

  hazard_scoreboard u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid_d    (valid_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rd_d       (rd_d),
    .regwrite_d (regwrite_d),
    .lat_d      (lat_d),
    .kill_d     (kill_d),
    .hold       (hold),
    .stall_d    (stall_d),
    .issue      (issue),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .busy_vec   (busy_vec),
    .retire     (retire),
    .retire_rd  (retire_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_d    = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    rd_d       = '0;
    regwrite_d = 1'b0;
    lat_d      = '0;
    kill_d     = 1'b0;
    hold       = 1'b0;
  endtask

  task automatic wr(input logic [RegAw-1:0] rd, input logic [LatW-1:0] lat);
    idle();
    valid_d    = 1'b1;
    rd_d       = rd;
    regwrite_d = 1'b1;
    lat_d      = lat;
  endtask

  task automatic rd_a(input logic [RegAw-1:0] rs);
    idle();
    valid_d  = 1'b1;
    rs1_d    = rs;
    rs1_used = 1'b1;
  endtask

  task automatic rd_b(input logic [RegAw-1:0] rs);
    idle();
    valid_d  = 1'b1;
    rs2_d    = rs;
    rs2_used = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check("reset_busy", busy_vec, 0);
    check("reset_retire", retire, 0);
    check("reset_stall", stall_d, 0);

    // Reset mid-flight
    wr(5, 4);
    #1 check("mf_issue", issue, 1);
    tick();
    idle();
    #1 check("mf_busy5", busy_vec, 32'h20);
    rd_a(5);
    resetn = 1'b0;
    #1 check("mf_rst_stall", stall_d, 0);
    check("mf_rst_fwd", fwd_a, 0);
    tick();
    resetn = 1'b1;
    idle();
    #1 check("mf_busy_clr", busy_vec, 0);
    check("mf_retire", retire, 0);
    rd_a(5);
    #1 check("mf_rd_stall", stall_d, 0);
    check("mf_rd_fwd", fwd_a, 0);
    check("mf_rd_issue", issue, 1);
    tick();

    // ALU forward
    wr(3, 2);
    tick();
    rd_a(3);
    #1 check("alu_stall", stall_d, 0);
    check("alu_fwd2", fwd_a, 2);
    check("alu_issue", issue, 1);
    tick();
    #1 check("alu_fwd1", fwd_a, 1);
    tick();
    idle();
    #1 check("alu_retire", retire, 1);
    check("alu_retire_rd", retire_rd, 3);
    check("alu_busy", busy_vec, 0);
    tick();
    check("alu_retire_off", retire, 0);

    // Load-use
    wr(7, 3);
    tick();
    rd_b(7);
    #1 check("lu_stall", stall_d, 1);
    check("lu_no_issue", issue, 0);
    tick();
    #1 check("lu_stall_off", stall_d, 0);
    check("lu_fwd_b", fwd_b, 2);
    check("lu_issue", issue, 1);
    tick();
    idle();
    tick();
    tick();
    tick();

    // WAW: older x9 lat 3, younger x9 lat 2
    wr(9, 3);
    tick();
    wr(9, 2);
    #1 check("waw_stall3", stall_d, 1);
    tick();
    #1 check("waw_stall2", stall_d, 1);
    tick();
    #1 check("waw_stall1", stall_d, 0);
    check("waw_issue", issue, 1);
    tick();
    idle();
    #1 check("waw_ret1", retire, 1);
    check("waw_ret1_rd", retire_rd, 9);
    check("waw_busy", busy_vec, 32'h200);
    tick();
    check("waw_gap", retire, 0);
    tick();
    check("waw_ret2", retire, 1);
    check("waw_ret2_rd", retire_rd, 9);
    check("waw_busy_clr", busy_vec, 0);
    tick();

    // Hold plus kill
    wr(4, 2);
    tick();
    idle();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", stall_d, 1);
      tick();
    end
    check("hold_busy", busy_vec, 32'h10);
    rd_a(4);
    hold = 1'b1;
    #1 check("hold_fwd", fwd_a, 2);
    check("hold_no_issue", issue, 0);
    wr(10, 1);
    rs1_d    = 4;
    rs1_used = 1'b1;
    kill_d   = 1'b1;
    #1 check("kill_stall", stall_d, 0);
    check("kill_fwd", fwd_a, 2);
    check("kill_issue", issue, 0);
    tick();
    idle();
    #1 check("kill_busy", busy_vec, 32'h10);
    tick();
    check("kill_retire_rd", retire_rd, 4);
    check("kill_retire", retire, 1);
    tick();

    // Hold suppresses a pending retire
    wr(11, 1);
    tick();
    idle();
    hold = 1'b1;
    tick();
    check("hold_ret_off", retire, 0);
    check("hold_ret_busy", busy_vec, 32'h800);
    hold = 1'b0;
    tick();
    check("hold_ret_on", retire_rd, 11);
    check("hold_ret_busy_clr", busy_vec, 0);
    tick();

    // x0 is never tracked
    wr(0, 2);
    #1 check("x0_issue", issue, 1);
    tick();
    rd_a(0);
    #1 check("x0_busy", busy_vec, 0);
    check("x0_fwd", fwd_a, 0);
    tick();

    // Re-issue x6 in the cycle its old entry retires
    wr(6, 1);
    tick();
    wr(6, 2);
    #1 check("re6_issue", issue, 1);
    tick();
    rd_a(6);
    #1 check("re6_busy", busy_vec, 32'h40);
    check("re6_ret", retire_rd, 6);
    check("re6_fwd2", fwd_a, 2);
    tick();
    #1 check("re6_fwd1", fwd_a, 1);
    tick();
    idle();
    #1 check("re6_busy_clr", busy_vec, 0);
    tick();

    // Simultaneous retires report the lowest register
    wr(12, 2);
    tick();
    wr(8, 1);
    tick();
    idle();
    #1 check("multi_busy", busy_vec, 32'h1100);
    tick();
    check("multi_ret_rd", retire_rd, 8);
    check("multi_busy_clr", busy_vec, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline's combinational hazard unit. It tracks every in-flight register write with its own countdown, so the core can mix ALU, load and multi-cycle operations with different result latencies. Each cycle it produces the decode-stage stall and per-operand forwarding selects from registered state. It sits between the decode stage and the datapath forwarding muxes, and replaces the fixed E/M/W comparator logic.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hard-wired zero and never tracked.
- REG_AW, 5: register address width; NUM_REGS <= 2**REG_AW.
- MAX_LAT, 4: largest result latency accepted on lat_d.
- FWD_DEPTH, 2: a pending result can be forwarded when its countdown is in 1..FWD_DEPTH.
- LAT_W, $clog2(MAX_LAT+1): countdown and select width.

Ports:
- clk, in, 1: core clock; the only clock.
- resetn, in, 1: synchronous, active-low reset.
- valid_d, in, 1: decode stage holds an instruction.
- rs1_d / rs2_d, in, REG_AW each: source registers.
- rs1_used / rs2_used, in, 1 each: the operand is actually read.
- rd_d, in, REG_AW: destination register.
- regwrite_d, in, 1: instruction writes rd_d.
- lat_d, in, LAT_W: result latency in cycles, legal range 1..MAX_LAT.
- kill_d, in, 1: branch flush; the decode instruction is discarded and not issued.
- hold, in, 1: global pipeline freeze, e.g. memory wait.
- stall_d, out, 1: hold fetch and decode.
- issue, out, 1: the decode instruction issues this cycle.
- fwd_a / fwd_b, out, LAT_W each: 0 selects the register file; k in 1..FWD_DEPTH selects the bypass of the result with k cycles remaining.
- busy_vec, out, NUM_REGS: pending-write flags, bit 0 always 0.
- retire, out, 1 and retire_rd, out, REG_AW: pulse when an entry's countdown reaches 0.

## Operation
- State held per register r: busy[r] and cnt[r] (LAT_W bits).
- Read-after-write hazard on operand X: valid_d, Xused, rsX != 0, busy[rsX] and cnt[rsX] > FWD_DEPTH.
- Write-after-write hazard: valid_d, regwrite_d, rd_d != 0, busy[rd_d] and cnt[rd_d] >= lat_d. This prevents a younger write finishing before or together with an older one.
- stall_d = (any RAW or WAW hazard) or hold. kill_d does not affect stall_d.
- issue = valid_d & ~stall_d & ~kill_d.
- fwd_X = cnt[rsX] when Xused, rsX != 0, busy[rsX] and 1 <= cnt[rsX] <= FWD_DEPTH; otherwise 0.
- Each non-hold cycle, every busy entry decrements. When an entry goes from 1 to 0: clear busy, pulse retire with retire_rd = r.
- If more than one entry reaches 0 in the same cycle, report the lowest-numbered one on retire_rd. All of them still clear.
- On issue with regwrite_d and rd_d != 0: busy[rd_d] <= 1 and cnt[rd_d] <= lat_d. This write has priority over the decrement or retire of the same entry in that cycle.
- Issue writes with rd_d = 0 or lat_d = 0 are ignored; lat_d = 0 is illegal input.
- hold = 1 freezes all counters and busy flags, suppresses retire and blocks issue. Combinational fwd/stall outputs still reflect the frozen state.

## Timing
- stall_d, issue and fwd_a/b are combinational from the inputs and registered state. All state updates on the rising edge of clk.
- An instruction issued at edge t shows busy = 1, cnt = lat_d after t. Its dependents see a forward select from the first cycle in which cnt <= FWD_DEPTH. Its result is retired lat_d non-hold edges after issue.
- retire is a registered one-cycle pulse, asserted in the cycle after the 1->0 edge.
- Reset (resetn = 0 sampled at an edge) clears all busy and cnt bits, retire = 0 and retire_rd = 0, including mid-operation. During reset, stall_d = hold and fwd_a = fwd_b = 0.
- No latency is added when there is no hazard: back-to-back independent instructions issue every cycle.

## Test plan
- Reset mid-flight: issue rd = 5, lat = 4. Assert resetn = 0 one cycle later -> busy_vec = 0, no retire, next instruction reading x5 sees fwd_a = 0 and stall_d = 0.
- ALU forward: issue x3 with lat = 2, then an instruction reading x3 as rs1 -> stall_d = 0, fwd_a = 2. One cycle later the same read gives fwd_a = 1. retire with retire_rd = 3 follows.
- Load-use: issue x7 with lat = 3, FWD_DEPTH = 2, then an instruction reading x7 as rs2 -> stall_d = 1 for exactly one cycle, then fwd_b = 2 and issue = 1.
- WAW: x9 pending with cnt = 3, new write to x9 with lat = 2 -> stall_d = 1 until cnt[x9] = 1, then issue. Exactly two retire pulses for rd = 9, in order.
- Hold plus kill: x4 pending with cnt = 2, hold = 1 for 3 cycles -> cnt stays 2, stall_d = 1. kill_d with valid_d and no hazard -> issue = 0 and busy_vec unchanged.
- x0 and simultaneous events: a write to x0 is never tracked. Issuing x6 in the cycle its old entry retires -> busy[6] stays 1 with cnt = the new lat_d.
